// File: rtl/tron_pkg.sv
// tron_pkg: shared TRON state encoding, default arena bounds and colours.
package tron_pkg;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CLEAR   = 2'd1;
    localparam logic [1:0] ST_BORDER  = 2'd2;
    localparam logic [1:0] ST_PLAYERS = 2'd3;
    localparam int DEF_ARENA_X0 = 20;
    localparam int DEF_ARENA_Y0 = 20;
    localparam int DEF_ARENA_X1 = 50;
    localparam int DEF_ARENA_Y1 = 50;
    localparam logic [2:0] DEF_BORDER_COLOR = 3'b111;
    localparam logic [2:0] COLOR_BLACK      = 3'b000;
endpackage

// File: rtl/tron_border_walker.sv
// tron_border_walker: clockwise arena-border coordinate generator starting at
// the top-left corner; last_o flags the final border pixel (X0, Y0+1).
module tron_border_walker #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int X0  = 20,
    parameter int Y0  = 20,
    parameter int X1  = 50,
    parameter int Y1  = 50
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           init_i,
    input  logic           step_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);
    localparam logic [X_W-1:0] XL = X_W'(X0);
    localparam logic [X_W-1:0] XR = X_W'(X1);
    localparam logic [Y_W-1:0] YT = Y_W'(Y0);
    localparam logic [Y_W-1:0] YB = Y_W'(Y1);
    localparam logic [Y_W-1:0] YE = Y_W'(Y0 + 1);
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (init_i) begin
            x_d = XL;
            y_d = YT;
        end else if (step_i) begin
            if (y_q == YT && x_q < XR) x_d = x_q + 1'b1;
            else if (x_q == XR && y_q < YB) y_d = y_q + 1'b1;
            else if (y_q == YB && x_q > XL) x_d = x_q - 1'b1;
            else y_d = y_q - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= XL;
            y_q <= YT;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = x_q == XL && y_q == YE;
endmodule

// File: rtl/tron_frame_drawer.sv
// tron_frame_drawer: per-frame TRON pixel emitter (border, then player heads).
// Define TRON_FRAME_CLEAR_EN to blank the arena interior before the border.
module tron_frame_drawer
    import tron_pkg::*;
#(
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int C_W         = 3,
    parameter int NUM_PLAYERS = 2,
    parameter int ARENA_X0    = DEF_ARENA_X0,
    parameter int ARENA_Y0    = DEF_ARENA_Y0,
    parameter int ARENA_X1    = DEF_ARENA_X1,
    parameter int ARENA_Y1    = DEF_ARENA_Y1,
    parameter logic [C_W-1:0] BORDER_COLOR = C_W'(DEF_BORDER_COLOR)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       pixel_en,
    input  logic [NUM_PLAYERS*X_W-1:0] player_x,
    input  logic [NUM_PLAYERS*Y_W-1:0] player_y,
    input  logic [NUM_PLAYERS*C_W-1:0] player_color,
    output logic [X_W-1:0]             x_out,
    output logic [Y_W-1:0]             y_out,
    output logic [C_W-1:0]             color_out,
    output logic                       plot,
    output logic                       busy,
    output logic                       done
);
    localparam int I_W = $clog2(NUM_PLAYERS + 1);
    localparam logic [I_W-1:0] LAST_IDX = I_W'(NUM_PLAYERS);
`ifdef TRON_FRAME_CLEAR_EN
    localparam logic [1:0] ST_FIRST = ST_CLEAR;
`else
    localparam logic [1:0] ST_FIRST = ST_BORDER;
`endif
    logic [1:0] state_q, state_d;
    logic [I_W-1:0] idx_q;
    logic [NUM_PLAYERS*X_W-1:0] snap_x_q, sx_sh;
    logic [NUM_PLAYERS*Y_W-1:0] snap_y_q, sy_sh;
    logic [NUM_PLAYERS*C_W-1:0] snap_c_q, sc_sh;
    logic [X_W-1:0] x_q, x_d, bx, px;
    logic [Y_W-1:0] y_q, y_d, by, py;
    logic [C_W-1:0] c_q, c_d, pc;
    logic plot_q, plot_d, busy_q, busy_d, done_q, done_d;
    logic b_last, p_in;
    tron_border_walker #(
        .X_W(X_W), .Y_W(Y_W), .X0(ARENA_X0), .Y0(ARENA_Y0), .X1(ARENA_X1), .Y1(ARENA_Y1)
    ) u_walker (
        .clk(clk), .reset(reset), .init_i(state_q != ST_BORDER), .step_i(pixel_en),
        .x_o(bx), .y_o(by), .last_o(b_last)
    );
`ifdef TRON_FRAME_CLEAR_EN
    logic [X_W-1:0] cx_q;
    logic [Y_W-1:0] cy_q;
    logic clr_row_end, clr_last;
    assign clr_row_end = cx_q == X_W'(ARENA_X1 - 1);
    assign clr_last    = clr_row_end && cy_q == Y_W'(ARENA_Y1 - 1);
    always_ff @(posedge clk) begin
        if (reset || state_q != ST_CLEAR) begin
            cx_q <= X_W'(ARENA_X0 + 1);
            cy_q <= Y_W'(ARENA_Y0 + 1);
        end else if (pixel_en) begin
            cx_q <= clr_row_end ? X_W'(ARENA_X0 + 1) : cx_q + 1'b1;
            cy_q <= clr_row_end ? cy_q + 1'b1 : cy_q;
        end
    end
`endif
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = start ? ST_FIRST : ST_IDLE;
`ifdef TRON_FRAME_CLEAR_EN
            ST_CLEAR:   state_d = (pixel_en && clr_last) ? ST_BORDER : ST_CLEAR;
`endif
            ST_BORDER:  state_d = (pixel_en && b_last) ? ST_PLAYERS : ST_BORDER;
            ST_PLAYERS: state_d = (pixel_en && idx_q == LAST_IDX) ? ST_IDLE : ST_PLAYERS;
            default:    state_d = ST_IDLE;
        endcase
    end
    // Index NUM_PLAYERS is the closing step that raises done.
    always_ff @(posedge clk) begin
        if (reset || state_q != ST_PLAYERS) idx_q <= '0;
        else if (pixel_en) idx_q <= idx_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_x_q <= '0;
            snap_y_q <= '0;
            snap_c_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            snap_x_q <= player_x;
            snap_y_q <= player_y;
            snap_c_q <= player_color;
        end
    end
    assign sx_sh = snap_x_q >> (X_W * int'(idx_q));
    assign sy_sh = snap_y_q >> (Y_W * int'(idx_q));
    assign sc_sh = snap_c_q >> (C_W * int'(idx_q));
    assign px    = sx_sh[X_W-1:0];
    assign py    = sy_sh[Y_W-1:0];
    assign pc    = sc_sh[C_W-1:0];
    assign p_in  = px > X_W'(ARENA_X0) && px < X_W'(ARENA_X1) &&
                   py > Y_W'(ARENA_Y0) && py < Y_W'(ARENA_Y1);
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        c_d    = c_q;
        plot_d = 1'b0;
        done_d = 1'b0;
        busy_d = state_d != ST_IDLE;
        if (pixel_en) begin
            case (state_q)
`ifdef TRON_FRAME_CLEAR_EN
                ST_CLEAR: begin
                    x_d    = cx_q;
                    y_d    = cy_q;
                    c_d    = C_W'(COLOR_BLACK);
                    plot_d = 1'b1;
                end
`endif
                ST_BORDER: begin
                    x_d    = bx;
                    y_d    = by;
                    c_d    = BORDER_COLOR;
                    plot_d = 1'b1;
                end
                ST_PLAYERS: begin
                    x_d    = (idx_q == LAST_IDX) ? x_q : px;
                    y_d    = (idx_q == LAST_IDX) ? y_q : py;
                    c_d    = (idx_q == LAST_IDX) ? c_q : pc;
                    plot_d = idx_q != LAST_IDX && p_in;
                    done_d = idx_q == LAST_IDX;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            c_q    <= '0;
            plot_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            c_q    <= c_d;
            plot_q <= plot_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign color_out = c_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_tron_frame_drawer.sv
// tb_tron_frame_drawer: directed frame checks for tron_frame_drawer (default
// parameters; honours TRON_FRAME_CLEAR_EN for the interior-blanking prefix).
module tb_tron_frame_drawer;
`ifdef TRON_FRAME_CLEAR_EN
    localparam int CLR = 841;
`else
    localparam int CLR = 0;
`endif
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, pixel_en = 1'b1;
    logic [15:0] player_x;
    logic [13:0] player_y;
    logic [5:0]  player_color;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  color_out;
    logic        plot, busy, done;
    int n_tests = 0, n_fail = 0;
    int done_k, odd_plots;
    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];
    always #5 clk = ~clk;
    tron_frame_drawer dut (
        .clk(clk), .reset(reset), .start(start), .pixel_en(pixel_en),
        .player_x(player_x), .player_y(player_y), .player_color(player_color),
        .x_out(x_out), .y_out(y_out), .color_out(color_out),
        .plot(plot), .busy(busy), .done(done)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [17:0] pix(input int x, input int y, input int c);
        return {8'(x), 7'(y), 3'(c)};
    endfunction
    function automatic logic [17:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 18'h3ffff;
    endfunction
    task automatic build_exp(input bit p0_in, input bit p1_in);
        exp_q.delete();
`ifdef TRON_FRAME_CLEAR_EN
        for (int y = 21; y <= 49; y++)
            for (int x = 21; x <= 49; x++) exp_q.push_back(pix(x, y, 0));
`endif
        for (int x = 20; x < 50; x++) exp_q.push_back(pix(x, 20, 7));
        for (int y = 20; y < 50; y++) exp_q.push_back(pix(50, y, 7));
        for (int x = 50; x > 20; x--) exp_q.push_back(pix(x, 50, 7));
        for (int y = 50; y > 20; y--) exp_q.push_back(pix(20, y, 7));
        if (p0_in) exp_q.push_back(pix(player_x[7:0], player_y[6:0], player_color[2:0]));
        if (p1_in) exp_q.push_back(pix(player_x[15:8], player_y[13:7], player_color[5:3]));
    endtask
    task automatic compare_seq(input string tag);
        check({tag, "_plot_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_pixel"}, got_q[i], exp_q[i]);
    endtask
    // mode 1 toggles pixel_en 1,0,1,0; restart_k/reset_k inject events at that cycle.
    task automatic run_frame(input int mode, input int restart_k, input int reset_k);
        got_q.delete();
        done_k    = 0;
        odd_plots = 0;
        @(negedge clk);
        pixel_en = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 2500; k++) begin
            @(negedge clk);
            if (k == 1) check("busy_after_start", busy, 1);
            if (plot) begin
                got_q.push_back({x_out, y_out, color_out});
                if (k % 2 == 1) odd_plots++;
            end
            if (done_k != 0) begin
                check("done_one_cycle", done, 0);
                break;
            end
            if (done) begin
                done_k = k;
                check("busy_low_at_done", busy, 0);
            end
            if (reset_k != 0 && k == reset_k + 1) begin
                check("rst_plot", plot, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_xyc", {x_out, y_out, color_out}, 0);
                reset = 1'b0;
                break;
            end
            if (k == reset_k) reset = 1'b1;
            if (restart_k != 0 && k == restart_k) begin
                start        = 1'b1;
                player_x     = {8'd30, 8'd60};
                player_y     = {7'd35, 7'd10};
                player_color = {3'b101, 3'b001};
            end
            if (restart_k != 0 && k == restart_k + 1) start = 1'b0;
            if (mode == 1) pixel_en = (k % 2 == 1);
        end
    endtask
    task automatic set_players_default();
        player_x     = {8'd40, 8'd25};
        player_y     = {7'd45, 7'd30};
        player_color = {3'b010, 3'b100};
    endtask
    initial begin
        set_players_default();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_x", x_out, 0);
        check("reset_y", y_out, 0);
        check("reset_color", color_out, 0);
        check("reset_plot", plot, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 1'b0;
        build_exp(1, 1);
        run_frame(0, 0, 0);
        compare_seq("t1");
        check("t1_first_border", got_at(CLR), pix(20, 20, 7));
        check("t1_31st_border", got_at(CLR + 30), pix(50, 20, 7));
        check("t1_last_border", got_at(CLR + 119), pix(20, 21, 7));
        check("t1_player0", got_at(CLR + 120), pix(25, 30, 4));
        check("t1_player1", got_at(CLR + 121), pix(40, 45, 2));
        check("t1_done_cycle", done_k, 124 + CLR);
`ifdef TRON_FRAME_CLEAR_EN
        check("clr_first", got_at(0), pix(21, 21, 0));
        check("clr_last", got_at(840), pix(49, 49, 0));
`endif
        player_x = {8'd50, 8'd25};
        player_y = {7'd30, 7'd30};
        build_exp(1, 0);
        run_frame(0, 0, 0);
        compare_seq("t2");
        check("t2_done_cycle", done_k, 124 + CLR);
        set_players_default();
        build_exp(1, 1);
        run_frame(1, 0, 0);
        compare_seq("t3");
        check("t3_done_cycle", done_k, 2 * (123 + CLR));
        check("t3_plots_on_odd_cycles", odd_plots, 0);
        set_players_default();
        build_exp(1, 1);
        run_frame(0, 50, 0);
        compare_seq("t4");
        check("t4_done_cycle", done_k, 124 + CLR);
        set_players_default();
        run_frame(0, 0, 60);
        check("t5_no_done", done_k, 0);
        @(negedge clk);
        check("t5_idle_plot", plot, 0);
        check("t5_idle_busy", busy, 0);
        build_exp(1, 1);
        run_frame(0, 0, 0);
        compare_seq("t6");
        check("t6_restart_first", got_at(CLR), pix(20, 20, 7));
        check("t6_done_cycle", done_k, 124 + CLR);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
